// File: rtl/tipi_regbank.sv
// tipi_regbank: TI-99/4A <-> Raspberry Pi mailbox register bank.
// TI writes tx registers over the memory bus and reads rx registers back;
// the RPi loads rx registers and reads tx registers over a serial shift link.
module tipi_regbank #(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [15:0] BASE_ADDR   = 16'h5FF8,
   parameter int unsigned SEL_W       = $clog2(2 * CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dsr_en,
   input  logic [0:15]         ti_a,
   input  logic [0:WIDTH-1]    ti_data,
   input  logic                ti_memen,
   input  logic                ti_we,
   input  logic                ti_dbin,
   output logic [0:WIDTH-1]    ti_rdata,
   output logic                ti_rdata_oe,
   input  logic                rpi_sclk,
   input  logic                rpi_sle,
   input  logic [SEL_W-1:0]    rpi_regsel,
   input  logic                rpi_sdata_out,
   output logic                rpi_sdata_in,
   output logic [CHANNELS-1:0] tx_event,
   output logic [CHANNELS-1:0] rx_event
);

   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned SX_W = SEL_W + 1;
   localparam int unsigned NS   = SYNC_STAGES;

   // address decode
   logic [15:0]      addr;
   logic [15:0]      off;
   logic [15:0]      half;
   logic             in_win;
   logic             rx_hit;
   logic             tx_hit;
   logic [CH_W-1:0]  rx_idx;
   logic [CH_W-1:0]  tx_idx;
   logic             wr_raw;
   logic [WIDTH-1:0] wdata_raw;
   logic [WIDTH-1:0] rd_val;

   // synchronisers
   logic [NS-1:0]    wr_sync_q, wr_sync_d;
   logic [NS-1:0]    sclk_sync_q, sclk_sync_d;
   logic [NS-1:0]    sle_sync_q, sle_sync_d;
   logic [NS-1:0]    sdo_sync_q, sdo_sync_d;
   logic [WIDTH-1:0] wdat_sync_q [NS];
   logic [WIDTH-1:0] wdat_sync_d [NS];
   logic [CH_W-1:0]  widx_sync_q [NS];
   logic [CH_W-1:0]  widx_sync_d [NS];
   logic [SEL_W-1:0] sel_sync_q  [NS];
   logic [SEL_W-1:0] sel_sync_d  [NS];
   logic             wr_prev_q, wr_prev_d;
   logic             sclk_prev_q, sclk_prev_d;
   logic             sle_prev_q, sle_prev_d;

   // register state
   logic [WIDTH-1:0] rx_reg_q   [CHANNELS];
   logic [WIDTH-1:0] rx_reg_d   [CHANNELS];
   logic [WIDTH-1:0] rx_shift_q [CHANNELS];
   logic [WIDTH-1:0] rx_shift_d [CHANNELS];
   logic [WIDTH-1:0] tx_reg_q   [CHANNELS];
   logic [WIDTH-1:0] tx_reg_d   [CHANNELS];
   logic [WIDTH-1:0] tx_shadow_q, tx_shadow_d;
   logic [WIDTH-1:0] stage_data_q, stage_data_d;
   logic [CH_W-1:0]  stage_idx_q, stage_idx_d;
   logic [CHANNELS-1:0] tx_event_q, tx_event_d;
   logic [CHANNELS-1:0] rx_event_q, rx_event_d;
   logic             sdi_q, sdi_d;

   // per-cycle helpers
   logic             wr_now;
   logic             commit;
   logic             sclk_rise;
   logic             sle_rise;
   logic [SX_W-1:0]  sel;
   logic             sdo;
   logic             tx_sel;
   logic [WIDTH-1:0] shadow_v;

   assign addr      = ti_a;
   assign wdata_raw = ti_data;

   // Window decode: odd offsets 1..4*CHANNELS-1 map to rx then tx channels
   always_comb begin
      off    = addr - BASE_ADDR;
      half   = {1'b0, off[15:1]};
      in_win = off[0] && (half < 16'(2 * CHANNELS));
      rx_hit = in_win && (half < 16'(CHANNELS));
      tx_hit = in_win && !(half < 16'(CHANNELS));
      rx_idx = CH_W'(half);
      tx_idx = CH_W'(half - 16'(CHANNELS));
      wr_raw = dsr_en & ~ti_memen & ~ti_we & tx_hit;
   end

   // Combinational TI read path straight from the bus pins
   always_comb begin
      ti_rdata_oe = dsr_en & ~ti_memen & ti_dbin & rx_hit;
      rd_val      = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (ti_rdata_oe && (rx_idx == CH_W'(k))) rd_val = rx_reg_q[k];
      end
      ti_rdata = rd_val;
   end

   // Next-state: synchronisers, write commit, RPi shift/latch and shadow
   always_comb begin
      wr_sync_d    = {wr_sync_q[NS-2:0], wr_raw};
      sclk_sync_d  = {sclk_sync_q[NS-2:0], rpi_sclk};
      sle_sync_d   = {sle_sync_q[NS-2:0], rpi_sle};
      sdo_sync_d   = {sdo_sync_q[NS-2:0], rpi_sdata_out};
      wdat_sync_d[0] = wdata_raw;
      widx_sync_d[0] = tx_idx;
      sel_sync_d[0]  = rpi_regsel;
      for (int i = 1; i < NS; i++) begin
         wdat_sync_d[i] = wdat_sync_q[i-1];
         widx_sync_d[i] = widx_sync_q[i-1];
         sel_sync_d[i]  = sel_sync_q[i-1];
      end
      wr_prev_d    = wr_sync_q[NS-1];
      sclk_prev_d  = sclk_sync_q[NS-1];
      sle_prev_d   = sle_sync_q[NS-1];
      rx_reg_d     = rx_reg_q;
      rx_shift_d   = rx_shift_q;
      tx_reg_d     = tx_reg_q;
      stage_data_d = stage_data_q;
      stage_idx_d  = stage_idx_q;
      tx_event_d   = '0;
      rx_event_d   = '0;
      tx_sel       = 1'b0;
      shadow_v     = tx_shadow_q;

      wr_now    = wr_sync_q[NS-1];
      commit    = wr_prev_q & ~wr_now;
      sclk_rise = sclk_sync_q[NS-1] & ~sclk_prev_q;
      sle_rise  = sle_sync_q[NS-1] & ~sle_prev_q;
      sel       = {1'b0, sel_sync_q[NS-1]};
      sdo       = sdo_sync_q[NS-1];

      if (wr_now) begin
         stage_data_d = wdat_sync_q[NS-1];
         stage_idx_d  = widx_sync_q[NS-1];
      end

      for (int k = 0; k < CHANNELS; k++) begin
         if (commit && (stage_idx_q == CH_W'(k))) begin
            tx_reg_d[k]   = stage_data_q;
            tx_event_d[k] = 1'b1;
         end
      end

      // rx: latch uses the pre-shift value, so a same-cycle shift lands after it
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SX_W'(k)) begin
            if (sle_rise) begin
               rx_reg_d[k]   = rx_shift_q[k];
               rx_event_d[k] = 1'b1;
            end
            if (sclk_rise) rx_shift_d[k] = {rx_shift_q[k][WIDTH-2:0], sdo};
         end
      end

      // tx: load (with commit bypass) first, then shift the loaded value
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SX_W'(CHANNELS + k)) begin
            tx_sel = 1'b1;
            if (sle_rise) begin
               if (commit && (stage_idx_q == CH_W'(k))) shadow_v = stage_data_q;
               else                                    shadow_v = tx_reg_q[k];
            end
         end
      end
      if (tx_sel && sclk_rise) shadow_v = shadow_v << 1;
      tx_shadow_d = shadow_v;
      sdi_d       = tx_sel & tx_shadow_q[WIDTH-1];
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_sync_q    <= '0;
         sclk_sync_q  <= '0;
         sle_sync_q   <= '0;
         sdo_sync_q   <= '0;
         for (int i = 0; i < NS; i++) begin
            wdat_sync_q[i] <= '0;
            widx_sync_q[i] <= '0;
            sel_sync_q[i]  <= '0;
         end
         wr_prev_q    <= 1'b0;
         sclk_prev_q  <= 1'b0;
         sle_prev_q   <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            rx_reg_q[k]   <= '0;
            rx_shift_q[k] <= '0;
            tx_reg_q[k]   <= '0;
         end
         tx_shadow_q  <= '0;
         stage_data_q <= '0;
         stage_idx_q  <= '0;
         tx_event_q   <= '0;
         rx_event_q   <= '0;
         sdi_q        <= 1'b0;
      end else begin
         wr_sync_q    <= wr_sync_d;
         sclk_sync_q  <= sclk_sync_d;
         sle_sync_q   <= sle_sync_d;
         sdo_sync_q   <= sdo_sync_d;
         wdat_sync_q  <= wdat_sync_d;
         widx_sync_q  <= widx_sync_d;
         sel_sync_q   <= sel_sync_d;
         wr_prev_q    <= wr_prev_d;
         sclk_prev_q  <= sclk_prev_d;
         sle_prev_q   <= sle_prev_d;
         rx_reg_q     <= rx_reg_d;
         rx_shift_q   <= rx_shift_d;
         tx_reg_q     <= tx_reg_d;
         tx_shadow_q  <= tx_shadow_d;
         stage_data_q <= stage_data_d;
         stage_idx_q  <= stage_idx_d;
         tx_event_q   <= tx_event_d;
         rx_event_q   <= rx_event_d;
         sdi_q        <= sdi_d;
      end
   end

   assign tx_event     = tx_event_q;
   assign rx_event     = rx_event_q;
   assign rpi_sdata_in = sdi_q;

endmodule

// File: tb/tb_tipi_regbank.sv
// Self-checking bench for tipi_regbank against a transaction-level mailbox model.
module tb_tipi_regbank;

   localparam int unsigned CH   = 2;
   localparam logic [15:0] BASE = 16'h5FF8;

   logic        clk = 1'b0;
   logic        rst;
   logic        dsr_en;
   logic [0:15] ti_a;
   logic [0:7]  ti_data;
   logic        ti_memen;
   logic        ti_we;
   logic        ti_dbin;
   logic [0:7]  ti_rdata;
   logic        ti_rdata_oe;
   logic        rpi_sclk;
   logic        rpi_sle;
   logic [1:0]  rpi_regsel;
   logic        rpi_sdata_out;
   logic        rpi_sdata_in;
   logic [1:0]  tx_event;
   logic [1:0]  rx_event;

   // second instance with three channels for out-of-range select
   logic [2:0]  regsel3;
   logic [0:7]  ti_rdata3;
   logic        ti_rdata_oe3;
   logic        sdi3;
   logic [2:0]  tx_event3;
   logic [2:0]  rx_event3;

   int n_chk = 0;
   int n_err = 0;
   int tx_cnt [2] = '{0, 0};
   int rx_cnt [2] = '{0, 0};
   int tx3_cnt = 0;
   int rx3_cnt = 0;

   logic [7:0] m_rx [2];
   logic [7:0] m_tx [2];

   always #10 clk = ~clk;

   tipi_regbank u_dut (
      .clk(clk), .rst(rst), .dsr_en(dsr_en), .ti_a(ti_a), .ti_data(ti_data),
      .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
      .ti_rdata(ti_rdata), .ti_rdata_oe(ti_rdata_oe),
      .rpi_sclk(rpi_sclk), .rpi_sle(rpi_sle), .rpi_regsel(rpi_regsel),
      .rpi_sdata_out(rpi_sdata_out), .rpi_sdata_in(rpi_sdata_in),
      .tx_event(tx_event), .rx_event(rx_event)
   );

   tipi_regbank #(.CHANNELS(3)) u_dut3 (
      .clk(clk), .rst(rst), .dsr_en(dsr_en), .ti_a(ti_a), .ti_data(ti_data),
      .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
      .ti_rdata(ti_rdata3), .ti_rdata_oe(ti_rdata_oe3),
      .rpi_sclk(rpi_sclk), .rpi_sle(rpi_sle), .rpi_regsel(regsel3),
      .rpi_sdata_out(rpi_sdata_out), .rpi_sdata_in(sdi3),
      .tx_event(tx_event3), .rx_event(rx_event3)
   );

   // count event pulses away from the active edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (tx_event[k]) tx_cnt[k]++;
         if (rx_event[k]) rx_cnt[k]++;
      end
      for (int k = 0; k < 3; k++) begin
         if (tx_event3[k]) tx3_cnt++;
         if (rx_event3[k]) rx3_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int tx_ch_of(input logic [15:0] a);
      for (int k = 0; k < CH; k++)
         if (a == 16'(BASE + 1 + 2 * (CH + k))) return k;
      return -1;
   endfunction

   function automatic int rx_ch_of(input logic [15:0] a);
      for (int k = 0; k < CH; k++)
         if (a == 16'(BASE + 1 + 2 * k)) return k;
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < CH; k++) begin
         m_rx[k] = 8'h00;
         m_tx[k] = 8'h00;
      end
   endtask

   task automatic ti_write(input logic [15:0] a, input logic [7:0] d, input logic dsr);
      int k;
      logic [1:0] exp_ev;
      int b0, b1;
      k      = dsr ? tx_ch_of(a) : -1;
      exp_ev = (k >= 0) ? 2'(1 << k) : 2'b00;
      b0 = tx_cnt[0];
      b1 = tx_cnt[1];
      ti_a = a; ti_data = d; dsr_en = dsr;
      ti_memen = 1'b0; ti_we = 1'b0;
      tick(6);
      ti_we = 1'b1;
      tick(2);
      chk("tx_ev_early", 32'(tx_event), 32'h0);
      tick(1);
      chk("tx_ev_time", 32'(tx_event), 32'(exp_ev));
      ti_memen = 1'b1;
      tick(4);
      chk("tx_ev_cnt0", 32'(tx_cnt[0] - b0), 32'(exp_ev[0]));
      chk("tx_ev_cnt1", 32'(tx_cnt[1] - b1), 32'(exp_ev[1]));
      if (k >= 0) m_tx[k] = d;
   endtask

   task automatic ti_read(input logic [15:0] a, input logic dsr);
      int k;
      ti_a = a; dsr_en = dsr; ti_memen = 1'b0; ti_dbin = 1'b1;
      #1;
      k = dsr ? rx_ch_of(a) : -1;
      chk("rd_oe", 32'(ti_rdata_oe), (k >= 0) ? 32'h1 : 32'h0);
      chk("rd_data", 32'(ti_rdata), (k >= 0) ? 32'(m_rx[k]) : 32'h0);
      ti_dbin = 1'b0; ti_memen = 1'b1; dsr_en = 1'b1;
      tick(1);
   endtask

   task automatic sle_pulse(input logic [1:0] exp_mask);
      rpi_sle = 1'b1;
      tick(2);
      chk("rx_ev_early", 32'(rx_event), 32'h0);
      tick(1);
      chk("rx_ev_time", 32'(rx_event), 32'(exp_mask));
      tick(2);
      rpi_sle = 1'b0;
      tick(5);
   endtask

   task automatic sclk_bit(input logic b);
      rpi_sdata_out = b;
      tick(5);
      rpi_sclk = 1'b1;
      tick(5);
      rpi_sclk = 1'b0;
      tick(5);
   endtask

   task automatic shift_out(output logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         v[i] = rpi_sdata_in;
         sclk_bit(1'b0);
      end
      chk("sdo_drain", 32'(rpi_sdata_in), 32'h0);
   endtask

   task automatic rpi_rx_send(input int ch, input logic [7:0] v);
      int b;
      rpi_regsel = 2'(ch);
      tick(5);
      for (int i = 7; i >= 0; i--) sclk_bit(v[i]);
      b = rx_cnt[ch];
      sle_pulse(2'(1 << ch));
      chk("rx_ev_cnt", 32'(rx_cnt[ch] - b), 32'h1);
      m_rx[ch] = v;
   endtask

   task automatic rpi_tx_read(input int ch, output logic [7:0] v);
      rpi_regsel = 2'(CH + ch);
      tick(5);
      sle_pulse(2'b00);
      shift_out(v);
   endtask

   initial begin
      logic [7:0] v;
      logic [15:0] a;
      int b3;
      rst = 1'b1; dsr_en = 1'b1; ti_a = 16'h0000; ti_data = 8'h00;
      ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0;
      rpi_sclk = 1'b0; rpi_sle = 1'b0; rpi_regsel = 2'd0; rpi_sdata_out = 1'b0;
      regsel3 = 3'd7;
      model_reset();
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("rst_oe", 32'(ti_rdata_oe), 32'h0);
      chk("rst_rdata", 32'(ti_rdata), 32'h0);
      chk("rst_sdi", 32'(rpi_sdata_in), 32'h0);
      chk("rst_txev", 32'(tx_event), 32'h0);
      chk("rst_rxev", 32'(rx_event), 32'h0);

      // reset in the middle of a shift, then a clean transfer
      rpi_regsel = 2'd0;
      tick(5);
      for (int i = 0; i < 3; i++) sclk_bit(1'b1);
      rst = 1'b1;
      tick(2);
      model_reset();
      chk("mid_rst_sdi", 32'(rpi_sdata_in), 32'h0);
      chk("mid_rst_ev", 32'({tx_event, rx_event}), 32'h0);
      ti_read(16'h5FF9, 1'b1);
      rst = 1'b0;
      tick(2);
      rpi_rx_send(0, 8'hC3);
      ti_read(16'h5FF9, 1'b1);
      ti_read(16'h5FFB, 1'b1);

      // non-matching writes leave tx ch1 at zero
      ti_write(16'h5FFF, 8'hA5, 1'b0);
      ti_write(16'h5FFE, 8'hA5, 1'b1);
      rpi_tx_read(1, v);
      chk("tx1_untouched", 32'(v), 32'h0);

      // real write, serial read-back MSB first
      ti_write(16'h5FFF, 8'hA5, 1'b1);
      chk("dut3_tx_ev", 32'(tx3_cnt), 32'h1);
      rpi_regsel = 2'd3;
      tick(5);
      sle_pulse(2'b00);
      chk("a5_first_bit", 32'(rpi_sdata_in), 32'h1);
      shift_out(v);
      chk("a5_bits", 32'(v), 32'hA5);

      // rx path and TI read-back
      rpi_rx_send(0, 8'h3C);
      ti_read(16'h5FF9, 1'b1);
      ti_read(16'h5FFB, 1'b1);
      ti_read(16'h5FF9, 1'b0);

      // same-cycle commit and shadow load on tx ch0
      rpi_regsel = 2'd2;
      tick(5);
      ti_a = 16'h5FFD; ti_data = 8'h81; dsr_en = 1'b1;
      ti_memen = 1'b0; ti_we = 1'b0;
      tick(6);
      ti_we = 1'b1;
      rpi_sle = 1'b1;
      tick(3);
      chk("byp_tx_ev", 32'(tx_event), 32'h1);
      tick(2);
      rpi_sle = 1'b0;
      ti_memen = 1'b1;
      tick(5);
      m_tx[0] = 8'h81;
      chk("byp_first_bit", 32'(rpi_sdata_in), 32'h1);
      shift_out(v);
      chk("byp_byte", 32'(v), 32'h81);

      // out-of-range select on the three-channel instance
      rpi_regsel = 2'd3;
      regsel3 = 3'd7;
      tick(5);
      b3 = rx3_cnt;
      sle_pulse(2'b00);
      for (int i = 7; i >= 0; i--) begin
         chk("oor_sdi", 32'(sdi3), 32'h0);
         v[i] = rpi_sdata_in;
         sclk_bit(1'b1);
      end
      chk("oor_main_byte", 32'(v), 32'(m_tx[1]));
      chk("oor_rx_ev", 32'(rx3_cnt - b3), 32'h0);

      // randomized transactions
      for (int it = 0; it < 40; it++) begin
         int op, ch, r;
         op = int'($urandom_range(0, 3));
         ch = int'($urandom_range(0, CH - 1));
         case (op)
            0: begin
               r = int'($urandom_range(0, 9));
               a = (r < 8) ? 16'(BASE + 16'(r)) : 16'($urandom);
               ti_write(a, 8'($urandom), ($urandom_range(0, 3) != 0));
            end
            1: begin
               rpi_rx_send(ch, 8'($urandom));
               ti_read(16'h5FF9, 1'b1);
               ti_read(16'h5FFB, 1'b1);
            end
            2: begin
               rpi_tx_read(ch, v);
               chk("rnd_tx_byte", 32'(v), 32'(m_tx[ch]));
            end
            default: begin
               ti_read(16'(BASE + 16'($urandom_range(0, 9))), ($urandom_range(0, 3) != 0));
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
